// File: rtl/sub_serial.sv
// Bit-serial a - b - bin, LSB first; result valid W cycles after the accept edge.
// in_ready only in IDLE; result held in DONE until out_ready.
module sub_serial #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         zero,
  output logic         ovf
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  sa;
  logic [W-1:0]  sb;
  logic [W-1:0]  res;
  logic          amsb;
  logic          bmsb;
  logic          br;
  logic [CW-1:0] cnt;

  logic          d;
  logic          br_nxt;
  logic [W-1:0]  res_nxt;

  // Operands shift right so the current bit is always at position 0.
  always_comb begin
    d       = sa[0] ^ sb[0] ^ br;
    br_nxt  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    res_nxt = {d, res[W-1:1]};
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      amsb  <= 1'b0;
      bmsb  <= 1'b0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      zero  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sa    <= a;
            sb    <= b;
            amsb  <= a[W-1];
            bmsb  <= b[W-1];
            br    <= bin;
            res   <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= br_nxt;
          res <= res_nxt;
          cnt <= cnt + CW'(1);
          // Result outputs only change here, so they hold between operations.
          if (cnt == CW'(W - 1)) begin
            diff  <= res_nxt;
            bout  <= br_nxt;
            zero  <= (res_nxt == '0);
            ovf   <= (amsb ^ bmsb) & (amsb ^ res_nxt[W-1]);
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial: directed vectors plus a queue-based reference model.
module tb_sub_serial;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         zero;
  logic         ovf;

  int total    = 0;
  int passed   = 0;
  int accepts  = 0;
  int results  = 0;

  typedef logic [W+2:0] res_t;
  res_t q[$];

  sub_serial #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: full-width arithmetic, packed as {diff, bout, zero, ovf}.
  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
    logic [W:0]   full;
    logic [W-1:0] md;
    full = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    md   = full[W-1:0];
    return {md, full[W], (md == '0), (ma[W-1] ^ mb[W-1]) & (ma[W-1] ^ md[W-1])};
  endfunction

  // Compare process: checks outputs every valid cycle, tracks handshakes at the following edge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid) begin
        if (q.size() == 0) check("unexpected_out_valid", 32'(out_valid), 32'd0);
        else begin
          check("model_result", 32'({diff, bout, zero, ovf}), 32'(q[0]));
          if (out_ready) begin
            void'(q.pop_front());
            results++;
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, bin));
        accepts++;
      end
    end
  end

  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                       input logic [W-1:0] ed, input logic eb, input logic ez, input logic eo);
    int n;
    a = ia; b = ib; bin = ibin; in_valid = 1'b1; out_ready = 1'b1;
    check("in_ready_before", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < W + 4) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(W));
    check("diff", 32'(diff), 32'(ed));
    check("bout", 32'(bout), 32'(eb));
    check("zero", 32'(zero), 32'(ez));
    check("ovf", 32'(ovf), 32'(eo));
    check("in_ready_in_done", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("in_ready_after", 32'(in_ready), 32'd1);
    check("out_valid_after", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int n;
    int acc0;
    int res0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;

    // Model pins
    check("model_pin_7m3", 32'(model(4'd7, 4'd3, 1'b0)), 32'(7'b0100_000));
    check("model_pin_0m15m1", 32'(model(4'd0, 4'd15, 1'b1)), 32'(7'b0000_110));
    check("model_pin_8m1", 32'(model(4'd8, 4'd1, 1'b0)), 32'(7'b0111_001));

    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_outs", 32'({out_valid, diff, bout, zero, ovf}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(4'd7, 4'd3, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0);
    do_op(4'd3, 4'd7, 1'b0, 4'hC, 1'b1, 1'b0, 1'b0);
    do_op(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
    do_op(4'd5, 4'd5, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    do_op(4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1);
    do_op(4'd7, 4'hF, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1);

    // Backpressure: 6 - 2 - 1 = 3 held while out_ready is low
    a = 4'd6; b = 4'd2; bin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < W + 4) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_latency", 32'(n), 32'(W));
    for (int i = 0; i < 5; i++) begin
      a = 4'd1; b = 4'd1; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_result", 32'({diff, bout, zero, ovf}), 32'({4'd3, 3'b000}));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("bp_no_extra_op", 32'({in_ready, out_valid}), 32'b10);

    // Asynchronous reset two cycles into RUN
    a = 4'd12; b = 4'd3; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_outs", 32'({out_valid, diff, bout, zero, ovf}), 32'd0);
    #4 rst = 1'b0;
    @(posedge clk); #1;
    do_op(4'd9, 4'd2, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1);

    // Random regression with stalls on both sides
    acc0 = accepts;
    res0 = results;
    n = 0;
    while ((accepts - acc0) < 1000 && n < 40000) begin
      a = W'($urandom);
      b = W'($urandom);
      bin = 1'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("rand_drained", 32'(q.size()), 32'd0);
    check("rand_accepts", 32'(accepts - acc0), 32'd1000);
    check("rand_count", 32'(results - res0), 32'(accepts - acc0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
